// File: rtl/instr_encoder.sv
// Encodes R-type/addi field tuples into 32-bit MIPS words, queues them in a small FIFO
// and streams them to instruction memory at sequential word addresses.
module instr_encoder #(
    parameter int unsigned            DEPTH     = 4,
    parameter int unsigned            ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]      BASE_ADDR = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         type_i,
    input  logic [4:0]                   rs_i,
    input  logic [4:0]                   rt_i,
    input  logic [4:0]                   rd_i,
    input  logic [4:0]                   shamt_i,
    input  logic [5:0]                   funct_i,
    input  logic [15:0]                  imm_i,
    output logic                         mem_we_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [31:0]                  mem_data_o,
    input  logic                         mem_ack_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [15:0]                  words_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]       fifo_q [DEPTH];
    logic [31:0]       fifo_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       words_q, words_d;
    logic [31:0]       word;
    logic              push, pop;

    assign ready_o    = (count_q < CNT_W'(DEPTH));
    assign mem_we_o   = (count_q != '0);
    assign mem_data_o = fifo_q[rd_ptr_q];
    assign mem_addr_o = addr_q;
    assign count_o    = count_q;
    assign words_o    = words_q;

    always_comb begin
        word = type_i ? {6'b001000, rs_i, rt_i, imm_i}
                      : {6'b000000, rs_i, rt_i, rd_i, shamt_i, funct_i};
        push     = valid_i && ready_o;
        pop      = mem_we_o && mem_ack_i;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        words_d  = words_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
            words_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = word;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + ADDR_W'(4);
                if (words_q != 16'hFFFF)
                    words_d = words_q + 16'd1;
            end
            // Pointers wrap freely; occupancy alone tells full from empty.
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            words_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
        end
    end

endmodule
